// File: rtl/pulse2toggle_tx_pkg.sv
// Shared definitions for the pulse-to-toggle transmitter: FSM encoding and
// the default pending-counter width.
package pulse2toggle_tx_pkg;

    localparam int CNT_W_DEFAULT = 4;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ACK = 1'b1;

endpackage

// File: rtl/pulse2toggle_tx_sync.sv
// Two-flop single-bit synchronizer with synchronous reset, used to bring the
// far-side acknowledge toggle into the clk domain.
module pulse2toggle_tx_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/pulse2toggle_tx.sv
// Converts single-cycle event pulses into toggles on out, one per event, with
// a saturating queue for events arriving while a toggle awaits acknowledge.
//
// state       | meaning
// ST_IDLE     | no toggle outstanding; next event toggles out immediately
// ST_WAIT_ACK | out toggled, waiting for synchronized ack to match out
module pulse2toggle_tx
    import pulse2toggle_tx_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             ack_in,
    input  logic             ovf_clr,
    output logic             out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;
    logic             ack_s;
    logic             ack_det;

    pulse2toggle_tx_sync u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ack_in),
        .q     (ack_s)
    );

    assign ack_det = (state_q == ST_WAIT_ACK) && (ack_s == out_q);

    always_comb begin
        state_d    = state_q;
        out_d      = out_q;
        pending_d  = pending_q;
        overflow_d = overflow_q & ~ovf_clr;
        case (state_q)
            ST_IDLE: begin
                if (in) begin
                    out_d   = ~out_q;
                    state_d = ST_WAIT_ACK;
                end
            end
            default: begin
                if (ack_det) begin
                    // A new event at ack time is served directly, so the
                    // queue neither grows nor shrinks.
                    if (in) begin
                        out_d = ~out_q;
                    end else if (pending_q != '0) begin
                        out_d     = ~out_q;
                        pending_d = pending_q - CNT_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (in) begin
                    if (pending_q != CNT_MAX) begin
                        pending_d = pending_q + CNT_ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            out_q      <= 1'b0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign out      = out_q;
    assign busy     = (state_q == ST_WAIT_ACK);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_pulse2toggle_tx.sv
// Bench for pulse2toggle_tx: directed scenarios plus a long random run with a
// modelled far side, all compared cycle by cycle against an event-count model.
module tb_pulse2toggle_tx;

    localparam int CNT_W = 4;
    localparam int MAXP  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, in, ack_in, ovf_clr;
    logic             out, busy, overflow;
    logic [CNT_W-1:0] pending;

    always #5 clk = ~clk;

    pulse2toggle_tx #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .ack_in   (ack_in),
        .ovf_clr  (ovf_clr),
        .out      (out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic drv_in = 1'b0, drv_ack = 1'b0, drv_clr = 1'b0, drv_rst = 1'b0;

    // Reference model: counts of events sent, queued and dropped
    logic m_out = 1'b0, m_wait = 1'b0, m_ovf = 1'b0;
    logic m_s1 = 1'b0, m_s2 = 1'b0;
    int   m_pend = 0, m_drop = 0, m_pulses = 0;
    int   n_trans = 0;
    logic prev_out = 1'b0;

    bit   fs_en  = 1'b0;
    int   fs_cnt = 0;
    int   fs_max = 3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic model_edge();
        logic ack, nxt_ovf;
        if (drv_rst) begin
            m_out = 1'b0; m_wait = 1'b0; m_ovf = 1'b0;
            m_s1 = 1'b0; m_s2 = 1'b0;
            m_pend = 0; m_drop = 0; m_pulses = 0;
        end else begin
            ack     = m_wait && (m_s2 == m_out);
            nxt_ovf = m_ovf && !drv_clr;
            if (drv_in) m_pulses++;
            if (!m_wait) begin
                if (drv_in) begin
                    m_out  = ~m_out;
                    m_wait = 1'b1;
                end
            end else if (ack) begin
                if (drv_in || m_pend > 0) begin
                    m_out = ~m_out;
                    if (!drv_in) m_pend--;
                end else begin
                    m_wait = 1'b0;
                end
            end else if (drv_in) begin
                if (m_pend < MAXP) m_pend++;
                else begin
                    m_drop++;
                    nxt_ovf = 1'b1;
                end
            end
            m_ovf = nxt_ovf;
            m_s2  = m_s1;
            m_s1  = drv_ack;
        end
    endtask

    task automatic tick();
        if (fs_en) begin
            if (drv_ack != m_out) begin
                if (fs_cnt <= 0) drv_ack = m_out;
                else fs_cnt--;
            end else begin
                fs_cnt = $urandom_range(0, fs_max);
            end
        end
        reset   = drv_rst;
        in      = drv_in;
        ack_in  = drv_ack;
        ovf_clr = drv_clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("out", out, m_out);
        check("busy", busy, m_wait);
        check("pending", pending, m_pend);
        check("overflow", overflow, m_ovf);
        if (out !== prev_out) n_trans++;
        prev_out = out;
        drv_in  = 1'b0;
        drv_clr = 1'b0;
    endtask

    initial begin
        // reset state
        drv_rst = 1'b1;
        tick(); tick();
        drv_rst = 1'b0;
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_overflow", overflow, 0);

        // single event, far side echoes 3 cycles later
        repeat (4) tick();
        drv_in = 1'b1; tick();
        check("single_out", out, 1);
        check("single_busy", busy, 1);
        tick(); tick();
        drv_ack = 1'b1;
        tick(); check("single_busy_e1", busy, 1);
        tick(); check("single_busy_e2", busy, 1);
        tick(); check("single_busy_e3", busy, 0);
        check("single_pending", pending, 0);

        // three back-to-back events with ack withheld
        repeat (3) begin drv_in = 1'b1; tick(); end
        check("burst_out", out, 0);
        check("burst_pending", pending, 2);
        drv_ack = 1'b0;
        repeat (3) tick();
        check("burst_ack1_out", out, 1);
        check("burst_ack1_pending", pending, 1);
        drv_ack = 1'b1;
        repeat (3) tick();
        check("burst_ack2_out", out, 0);
        check("burst_ack2_pending", pending, 0);
        drv_ack = 1'b0;
        repeat (3) tick();
        check("burst_idle_busy", busy, 0);
        check("burst_idle_out", out, 0);

        // saturation and sticky overflow
        repeat (16) begin drv_in = 1'b1; tick(); end
        check("sat16_pending", pending, 15);
        check("sat16_overflow", overflow, 0);
        drv_in = 1'b1; tick();
        check("sat17_pending", pending, 15);
        check("sat17_overflow", overflow, 1);
        drv_clr = 1'b1; tick();
        check("clr_overflow", overflow, 0);
        check("clr_pending", pending, 15);
        drv_in = 1'b1; drv_clr = 1'b1; tick();
        check("set_wins_overflow", overflow, 1);
        drv_clr = 1'b1; tick();
        check("clr2_overflow", overflow, 0);

        // event in the exact ack-detect cycle
        drv_rst = 1'b1; drv_ack = 1'b0; tick();
        drv_rst = 1'b0;
        drv_in = 1'b1; tick();
        drv_ack = 1'b1; tick(); tick();
        drv_in = 1'b1; tick();
        check("ackin_p0_out", out, 0);
        check("ackin_p0_busy", busy, 1);
        check("ackin_p0_pending", pending, 0);
        repeat (3) begin drv_in = 1'b1; tick(); end
        check("ackin_p3_pre", pending, 3);
        drv_ack = 1'b0; tick(); tick();
        drv_in = 1'b1; tick();
        check("ackin_p3_out", out, 1);
        check("ackin_p3_pending", pending, 3);
        check("ackin_p3_busy", busy, 1);

        // reset mid-operation
        repeat (2) begin drv_in = 1'b1; tick(); end
        check("midrst_pre_pending", pending, 5);
        drv_rst = 1'b1; drv_in = 1'b1; drv_ack = 1'b0; tick();
        check("midrst_out", out, 0);
        check("midrst_pending", pending, 0);
        check("midrst_busy", busy, 0);
        check("midrst_overflow", overflow, 0);
        drv_rst = 1'b0; tick();
        check("postrst_busy", busy, 0);
        check("postrst_out", out, 0);

        // random run with modelled far side
        drv_rst = 1'b1; tick();
        drv_rst = 1'b0;
        n_trans = 0; prev_out = out;
        fs_en = 1'b1;
        begin
            int prob = 30;
            for (int c = 0; c < 10000; c++) begin
                if (c % 500 == 0) begin
                    fs_max = ($urandom_range(0, 1) != 0) ? 40 : 3;
                    prob   = $urandom_range(5, 80);
                end
                drv_in  = ($urandom_range(0, 99) < prob);
                drv_clr = ($urandom_range(0, 99) == 0);
                tick();
            end
        end
        for (int i = 0; i < 2000 && m_wait; i++) tick();
        check("drain_busy", busy, 0);
        check("conserve", n_trans + int'(pending) + m_drop, m_pulses);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
